aes_block_writer: RTL

- Output-side counterpart of the AES run harness.
- Accepts 128-bit result blocks from the ENCRYPT/DECRYPT pipeline (validOut/out), buffers them, and serializes each block into bytes.
- Writes the bytes into a byte-wide output Fifo through wreq/wdata, honouring full backpressure.
- Signals done once NBLOCKS blocks have been fully written. This replaces the bit-indexed output register plus fixed-cycle stop counter.

---
 rtl/aes_block_writer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/aes_block_writer.sv
// aes_block_writer: buffers 128-bit AES result blocks and serializes them,
// most significant byte first, into a byte-wide output FIFO with full
// backpressure. Raises a sticky done once NBLOCKS blocks have been written.
module aes_block_writer #(
  parameter int unsigned NBLOCKS = 1,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               validIn,
  input  logic [127:0]       in,
  input  logic               wfull,
  output logic               wreq,
  output logic [7:0]         wdata,
  output logic [CNT_W-1:0]   blocks_written,
  output logic               overflow,
  output logic               done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] NB_CNT   = CNT_W'(NBLOCKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBLOCKS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;

  logic [0:0]       state_q, state_d;
  logic [127:0]     mem [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [127:0]     sh_q;
  logic [3:0]       bi_q;
  logic [CNT_W-1:0] blocks_q;
  logic             overflow_q;
  logic             done_q;

  logic             write_c;
  logic             last_c;
  logic             finish_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // State register.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state, buffer handshake and write strobe decode.
  always_comb begin
    state_d  = state_q;
    write_c  = 1'b0;
    last_c   = 1'b0;
    finish_c = 1'b0;
    pop_c    = 1'b0;
    push_c   = 1'b0;
    drop_c   = 1'b0;

    write_c  = (state_q == SHIFT) && !wfull && !done_q;
    last_c   = write_c && (bi_q == 4'hF);
    finish_c = last_c && (blocks_q == LAST_CNT);
    // The block that completes the run must not pull another block in.
    pop_c    = !done_q && (count_q != '0) &&
               ((state_q == IDLE) || (last_c && !finish_c));
    push_c   = validIn && !done_q && ((count_q != FULL_CNT) || pop_c);
    drop_c   = validIn && !done_q && (count_q == FULL_CNT) && !pop_c;

    case (state_q)
      IDLE: begin
        if (pop_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_c && !pop_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done_q) state_d = IDLE;
  end

  // Block storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) mem[tail_q] <= in;
  end

  // Pointers, occupancy, serializer datapath and status.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      sh_q       <= '0;
      bi_q       <= '0;
      blocks_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (push_c) tail_q <= tail_q + AW'(1);
      if (pop_c)  head_q <= head_q + AW'(1);

      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (pop_c) begin
        sh_q <= mem[head_q];
        bi_q <= 4'h0;
      end else if (write_c) begin
        sh_q <= {sh_q[119:0], 8'h00};
        bi_q <= bi_q + 4'h1;
      end

      if (last_c && (blocks_q != NB_CNT)) blocks_q <= blocks_q + CNT_W'(1);
      if (finish_c) done_q     <= 1'b1;
      if (drop_c)   overflow_q <= 1'b1;
    end
  end

  assign wreq           = write_c;
  assign wdata          = sh_q[127:120];
  assign blocks_written = blocks_q;
  assign overflow       = overflow_q;
  assign done           = done_q;

endmodule
